// File: rtl/dcache_ctrl_pkg.sv
// Shared definitions for the direct-mapped write-through data cache:
// FSM state encoding and the address field-slice constants.
package dcache_ctrl_pkg;

  localparam int DC_ADDR_W   = 32;
  localparam int DC_DATA_W   = 32;
  localparam int DC_OFFSET_W = 2;
  localparam int DC_IDX_W    = 6;
  localparam int DC_TAG_W    = DC_ADDR_W - DC_OFFSET_W - DC_IDX_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MEM  = 2'd1,
    ST_RESP = 2'd2
  } dc_state_e;

endpackage

// File: rtl/dcache_array.sv
// Valid/tag/data storage for the data cache: one combinational read port,
// one synchronous write port, valid bits cleared by the async low reset.
module dcache_array
  import dcache_ctrl_pkg::*;
#(
  parameter int IDX_W = DC_IDX_W,
  parameter int TAG_W = DC_ADDR_W - DC_OFFSET_W - IDX_W
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [IDX_W-1:0]     rd_idx,
  output logic                 rd_valid,
  output logic [TAG_W-1:0]     rd_tag,
  output logic [DC_DATA_W-1:0] rd_data,
  input  logic                 wr_en,
  input  logic [IDX_W-1:0]     wr_idx,
  input  logic [TAG_W-1:0]     wr_tag,
  input  logic [DC_DATA_W-1:0] wr_data
);

  localparam int LINES = 1 << IDX_W;

  logic [LINES-1:0]     valid_q;
  logic [LINES-1:0]     valid_d;
  logic [TAG_W-1:0]     tag_mem  [LINES];
  logic [DC_DATA_W-1:0] data_mem [LINES];

  always_comb begin
    valid_d = valid_q;
    if (wr_en) begin
      valid_d[wr_idx] = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Tag and data are meaningless until the valid bit is set, so no reset.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      tag_mem[wr_idx]  <= wr_tag;
      data_mem[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_mem[rd_idx];
  assign rd_data  = data_mem[rd_idx];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, single-word-line, write-through, no-write-allocate data cache
// controller: CPU-side responder, backing-memory-side initiator.
module dcache_ctrl
  import dcache_ctrl_pkg::*;
#(
  parameter int IDX_W = DC_IDX_W
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [DC_ADDR_W-1:0] dcache_addr,
  output logic [DC_DATA_W-1:0] dcache_rdata,
  input  logic [DC_DATA_W-1:0] dcache_wdata,
  output logic                 dcache_rdy,
  input  logic                 dcache_en,
  input  logic                 dcache_wr,
  output logic [DC_ADDR_W-1:0] mem_addr,
  input  logic [DC_DATA_W-1:0] mem_rdata,
  output logic [DC_DATA_W-1:0] mem_wdata,
  input  logic                 mem_rdy,
  output logic                 mem_en,
  output logic                 mem_wr
);

  localparam int TAG_W = DC_ADDR_W - DC_OFFSET_W - IDX_W;

  dc_state_e            state_q, state_d;
  logic [DC_ADDR_W-1:0] addr_q, addr_d;
  logic [DC_DATA_W-1:0] wdata_q, wdata_d;
  logic                 wr_q, wr_d;
  logic                 hit_q, hit_d;
  logic [DC_DATA_W-1:0] rdata_q, rdata_d;
  logic                 rdy_q, rdy_d;
  logic                 mem_en_q, mem_en_d;
  logic                 mem_wr_q, mem_wr_d;

  logic [IDX_W-1:0]     req_idx;
  logic [TAG_W-1:0]     req_tag;
  logic                 arr_valid;
  logic [TAG_W-1:0]     arr_tag;
  logic [DC_DATA_W-1:0] arr_data;
  logic                 req_hit;
  logic                 arr_we;
  logic [DC_DATA_W-1:0] arr_wdata;

  assign req_idx = dcache_addr[DC_OFFSET_W +: IDX_W];
  assign req_tag = dcache_addr[DC_ADDR_W-1 -: TAG_W];
  assign req_hit = arr_valid && (arr_tag == req_tag);

  // Fills take the memory word; write hits refresh the line with CPU data.
  assign arr_wdata = wr_q ? wdata_q : mem_rdata;

  dcache_array #(
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_array (
    .clock    (clock),
    .reset    (reset),
    .rd_idx   (req_idx),
    .rd_valid (arr_valid),
    .rd_tag   (arr_tag),
    .rd_data  (arr_data),
    .wr_en    (arr_we),
    .wr_idx   (addr_q[DC_OFFSET_W +: IDX_W]),
    .wr_tag   (addr_q[DC_ADDR_W-1 -: TAG_W]),
    .wr_data  (arr_wdata)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    hit_d   = hit_q;
    rdata_d = rdata_q;
    arr_we  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (dcache_en) begin
          if (!dcache_wr && req_hit) begin
            rdata_d = arr_data;
            state_d = ST_RESP;
          end else begin
            addr_d  = dcache_addr & ~32'h3;
            wdata_d = dcache_wdata;
            wr_d    = dcache_wr;
            hit_d   = req_hit;
            state_d = ST_MEM;
          end
        end
      end
      ST_MEM: begin
        if (mem_rdy) begin
          state_d = ST_RESP;
          if (!wr_q) begin
            rdata_d = mem_rdata;
            arr_we  = 1'b1;
          end else if (hit_q) begin
            arr_we  = 1'b1;
          end
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Handshake outputs come straight from flops so they cannot glitch.
    rdy_d    = (state_d == ST_RESP);
    mem_en_d = (state_d == ST_MEM);
    mem_wr_d = (state_d == ST_MEM) && wr_d;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      wr_q     <= 1'b0;
      hit_q    <= 1'b0;
      rdata_q  <= '0;
      rdy_q    <= 1'b0;
      mem_en_q <= 1'b0;
      mem_wr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wr_q     <= wr_d;
      hit_q    <= hit_d;
      rdata_q  <= rdata_d;
      rdy_q    <= rdy_d;
      mem_en_q <= mem_en_d;
      mem_wr_q <= mem_wr_d;
    end
  end

  assign dcache_rdata = rdata_q;
  assign dcache_rdy   = rdy_q;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign mem_en       = mem_en_q;
  assign mem_wr       = mem_wr_q;

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: directed vector table, hand-written
// reset-mid-miss sequence, then random traffic against a cache/memory model.
module tb_dcache_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] dcache_addr;
  logic [31:0] dcache_rdata;
  logic [31:0] dcache_wdata;
  logic        dcache_rdy;
  logic        dcache_en;
  logic        dcache_wr;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic [31:0] mem_wdata;
  logic        mem_rdy;
  logic        mem_en;
  logic        mem_wr;

  int checks = 0;
  int errors = 0;

  dcache_ctrl dut (
    .clock        (clock),
    .reset        (reset),
    .dcache_addr  (dcache_addr),
    .dcache_rdata (dcache_rdata),
    .dcache_wdata (dcache_wdata),
    .dcache_rdy   (dcache_rdy),
    .dcache_en    (dcache_en),
    .dcache_wr    (dcache_wr),
    .mem_addr     (mem_addr),
    .mem_rdata    (mem_rdata),
    .mem_wdata    (mem_wdata),
    .mem_rdy      (mem_rdy),
    .mem_en       (mem_en),
    .mem_wr       (mem_wr)
  );

  always #5 clock = ~clock;

  // Reference model: each of 64 lines remembers which word address it holds.
  logic        ref_valid [64];
  logic [31:0] ref_word  [64];
  logic [31:0] ref_data  [64];
  logic [31:0] bmem [logic [31:0]];

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] mval;
    logic        exp_mem;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [12];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Runs one CPU request and plays the backing memory with lat_cfg cycles of delay.
  task automatic applyStimulus(input logic [31:0] a, input logic w, input logic [31:0] wd,
                               input int lat_cfg, input logic [31:0] mval,
                               output logic [31:0] rd, output int n_mem,
                               output logic [31:0] m_addr, output logic m_wr,
                               output logic [31:0] m_wdata, output int lat,
                               output logic stable, output logic done);
    int   cnt;
    logic prev_en;
    @(negedge clock);
    dcache_en    = 1'b1;
    dcache_addr  = a;
    dcache_wr    = w;
    dcache_wdata = wd;
    rd = '0; n_mem = 0; m_addr = '0; m_wr = 1'b0; m_wdata = '0;
    lat = 0; stable = 1'b1; done = 1'b0; cnt = 0; prev_en = 1'b0;
    for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
      @(negedge clock);
      mem_rdy   = 1'b0;
      mem_rdata = 32'h0BAD_0BAD;
      if (dcache_rdy) begin
        done = 1'b1;
        lat  = cyc;
        rd   = dcache_rdata;
      end else if (mem_en) begin
        if (!prev_en) begin
          n_mem++;
          m_addr  = mem_addr;
          m_wr    = mem_wr;
          m_wdata = mem_wdata;
          cnt     = 0;
        end else if (mem_addr !== m_addr || mem_wr !== m_wr || mem_wdata !== m_wdata) begin
          stable = 1'b0;
        end
        cnt++;
        if (cnt == lat_cfg) begin
          mem_rdy   = 1'b1;
          mem_rdata = mval;
        end
      end
      prev_en = mem_en;
    end
    dcache_en = 1'b0;
    mem_rdy   = 1'b0;
  endtask

  task automatic runAndCheck(input string tag, input logic [31:0] a, input logic w,
                             input logic [31:0] wd, input int lat_cfg, input logic [31:0] mval,
                             input logic exp_mem, input logic [31:0] exp_rd);
    logic [31:0] rd, m_addr, m_wdata;
    logic        m_wr, stable, done;
    int          n_mem, lat;
    applyStimulus(a, w, wd, lat_cfg, mval, rd, n_mem, m_addr, m_wr, m_wdata, lat, stable, done);
    checkOutput({tag, " completed"}, 32'(done), 32'd1);
    checkOutput({tag, " mem_count"}, 32'(n_mem), exp_mem ? 32'd1 : 32'd0);
    checkOutput({tag, " latency"}, 32'(lat), exp_mem ? 32'(lat_cfg + 1) : 32'd1);
    if (!w) checkOutput({tag, " rdata"}, rd, exp_rd);
    if (exp_mem) begin
      checkOutput({tag, " mem_addr"}, m_addr, a & ~32'h3);
      checkOutput({tag, " mem_wr"}, 32'(m_wr), 32'(w));
      checkOutput({tag, " mem_stable"}, 32'(stable), 32'd1);
      if (w) checkOutput({tag, " mem_wdata"}, m_wdata, wd);
    end
  endtask

  task automatic modelRequest(input logic [31:0] a, input logic w, input logic [31:0] wd,
                              output logic exp_mem, output logic [31:0] exp_rd,
                              output logic [31:0] mval);
    logic [31:0] word;
    int          line;
    logic        hit;
    word = a & ~32'h3;
    line = int'((a >> 2) % 64);
    hit  = ref_valid[line] && (ref_word[line] == word);
    mval = bmem.exists(word) ? bmem[word] : (word ^ 32'h5A5A_0000);
    exp_rd = '0;
    if (w) begin
      exp_mem    = 1'b1;
      bmem[word] = wd;
      if (hit) ref_data[line] = wd;
    end else if (hit) begin
      exp_mem = 1'b0;
      exp_rd  = ref_data[line];
    end else begin
      exp_mem         = 1'b1;
      exp_rd          = mval;
      ref_valid[line] = 1'b1;
      ref_word[line]  = word;
      ref_data[line]  = mval;
    end
  endtask

  initial begin
    logic [31:0] ra, rwd, exp_rd, mval;
    logic        rw, exp_mem;
    int          rlat;

    reset = 1'b0; dcache_en = 1'b0; dcache_wr = 1'b0;
    dcache_addr = '0; dcache_wdata = '0; mem_rdy = 1'b0; mem_rdata = '0;

    vecs[0]  = '{32'h0000_0100, 1'b0, 32'h0,          3, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF};
    vecs[1]  = '{32'h0000_0100, 1'b0, 32'h0,          1, 32'h0,         1'b0, 32'hDEAD_BEEF};
    vecs[2]  = '{32'h0000_0102, 1'b0, 32'h0,          1, 32'h0,         1'b0, 32'hDEAD_BEEF};
    vecs[3]  = '{32'h0000_0100, 1'b1, 32'h1234_5678,  2, 32'h0,         1'b1, 32'h0};
    vecs[4]  = '{32'h0000_0100, 1'b0, 32'h0,          1, 32'h0,         1'b0, 32'h1234_5678};
    vecs[5]  = '{32'h0000_0200, 1'b1, 32'hA5A5_A5A5,  1, 32'h0,         1'b1, 32'h0};
    vecs[6]  = '{32'h0000_0200, 1'b0, 32'h0,          2, 32'hA5A5_A5A5, 1'b1, 32'hA5A5_A5A5};
    vecs[7]  = '{32'h0000_0100, 1'b0, 32'h0,          1, 32'h1234_5678, 1'b1, 32'h1234_5678};
    vecs[8]  = '{32'h0000_0200, 1'b0, 32'h0,          3, 32'h1111_1111, 1'b1, 32'h1111_1111};
    vecs[9]  = '{32'h0000_0100, 1'b0, 32'h0,          2, 32'h1234_5678, 1'b1, 32'h1234_5678};
    vecs[10] = '{32'h0000_0104, 1'b0, 32'h0,          1, 32'hCAFE_F00D, 1'b1, 32'hCAFE_F00D};
    vecs[11] = '{32'h0000_0100, 1'b0, 32'h0,          1, 32'h0,         1'b0, 32'h1234_5678};

    #12;
    checkOutput("reset dcache_rdy", 32'(dcache_rdy), 32'd0);
    checkOutput("reset dcache_rdata", dcache_rdata, 32'd0);
    checkOutput("reset mem_en", 32'(mem_en), 32'd0);
    checkOutput("reset mem_wr", 32'(mem_wr), 32'd0);
    checkOutput("reset mem_addr", mem_addr, 32'd0);
    checkOutput("reset mem_wdata", mem_wdata, 32'd0);
    @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < 12; i++) begin
      runAndCheck($sformatf("vec%0d", i), vecs[i].addr, vecs[i].wr, vecs[i].wdata,
                  vecs[i].lat, vecs[i].mval, vecs[i].exp_mem, vecs[i].exp_rd);
    end

    // Reset in the middle of a miss, then a stray late mem_rdy.
    @(negedge clock);
    dcache_en = 1'b1; dcache_addr = 32'h0000_0300; dcache_wr = 1'b0;
    @(negedge clock);
    checkOutput("midrst mem_en before", 32'(mem_en), 32'd1);
    #2 reset = 1'b0;
    #1;
    checkOutput("midrst mem_en", 32'(mem_en), 32'd0);
    checkOutput("midrst dcache_rdy", 32'(dcache_rdy), 32'd0);
    checkOutput("midrst mem_addr", mem_addr, 32'd0);
    dcache_en = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    mem_rdy = 1'b1; mem_rdata = 32'h7777_7777;
    @(negedge clock);
    mem_rdy = 1'b0;
    checkOutput("late mem_rdy rdy", 32'(dcache_rdy), 32'd0);
    checkOutput("late mem_rdy mem_en", 32'(mem_en), 32'd0);
    @(negedge clock);
    checkOutput("late mem_rdy rdata", dcache_rdata, 32'd0);
    runAndCheck("post-reset 0x300", 32'h0000_0300, 1'b0, 32'h0, 2, 32'h3333_3333, 1'b1, 32'h3333_3333);
    runAndCheck("post-reset 0x104", 32'h0000_0104, 1'b0, 32'h0, 1, 32'hCAFE_F00D, 1'b1, 32'hCAFE_F00D);

    // Fresh start for random traffic against the model.
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 64; i++) begin
      ref_valid[i] = 1'b0;
      ref_word[i]  = '0;
      ref_data[i]  = '0;
    end
    bmem.delete();

    for (int n = 0; n < 150; n++) begin
      ra   = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
      rw   = ($urandom_range(0, 2) == 0);
      rwd  = $urandom;
      rlat = $urandom_range(1, 4);
      modelRequest(ra, rw, rwd, exp_mem, exp_rd, mval);
      runAndCheck($sformatf("rand%0d", n), ra, rw, rwd, rlat, mval, exp_mem, exp_rd);
    end

    $display("[TB] done");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
